// File: rtl/game_round_sequencer.sv
// game_round_sequencer: round controller for one bouncing sprite.
// Spawns the sprite (position/velocity load strobes), gates motion updates,
// counts wall bounces per life, scores catches, tracks lives and sequences
// IDLE -> SPAWN -> PLAY -> PAUSE -> GAME_OVER.
//
// Optional feature macro: GAME_SEQ_SPEEDUP_EN
//   defined   : spawn speed = 1 + min(score[3:2], 2)
//   undefined : spawn speed fixed at 1
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   tick                   slow movement strobe shared with the sprite block
//   launch                 start/restart pulse
//   collision              player caught the sprite (level)
//   hit_wall               wall hit from the sprite block
//   enable                 sprite block enable
//   sprite_enable_update   allow motion updates (PLAY only)
//   sprite_write_xy/_x/_y  position load strobe and spawn position
//   sprite_write_dxy/_dx/_dy velocity load strobe and signed spawn velocity
//   lives, score           remaining lives, saturating catch count
//   game_over              high in GAME_OVER
//   state                  encoded FSM state for debug
module game_round_sequencer #(
  parameter int unsigned screen_width  = 640,
  parameter int unsigned screen_height = 480,
  parameter int unsigned SPRITE_WIDTH  = 8,
  parameter int unsigned w_x           = $clog2(screen_width),
  parameter int unsigned w_y           = $clog2(screen_height),
  parameter int unsigned DX_WIDTH      = 3,
  parameter int unsigned DY_WIDTH      = 3,
  parameter int unsigned SPAWN_Y       = 0,
  parameter int unsigned LIVES_INIT    = 3,
  parameter int unsigned MAX_BOUNCES   = 8,
  parameter int unsigned PAUSE_TICKS   = 16,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                launch,
  input  logic                collision,
  input  logic                hit_wall,
  output logic                enable,
  output logic                sprite_enable_update,
  output logic                sprite_write_xy,
  output logic [w_x-1:0]      sprite_write_x,
  output logic [w_y-1:0]      sprite_write_y,
  output logic                sprite_write_dxy,
  output logic [DX_WIDTH-1:0] sprite_write_dx,
  output logic [DY_WIDTH-1:0] sprite_write_dy,
  output logic [2:0]          lives,
  output logic [7:0]          score,
  output logic                game_over,
  output logic [2:0]          state
);

  localparam int unsigned X_MAX = screen_width - SPRITE_WIDTH;
  localparam int unsigned BW    = $clog2(MAX_BOUNCES + 1);
  localparam int unsigned PW    = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;
  localparam logic [w_x:0] X_MAX_L = (w_x + 1)'(X_MAX);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SPAWN     = 3'd1,
    S_PLAY      = 3'd2,
    S_PAUSE     = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    lives_q, lives_d;
  logic [7:0]    score_q, score_d;
  logic [BW-1:0] bounce_q, bounce_d;
  logic [PW-1:0] pause_q, pause_d;
  logic [15:0]   lfsr_q, lfsr_d;

  logic                enable_q, upd_q, game_over_q;
  logic                wr_xy_q, wr_dxy_q;
  logic [w_x-1:0]      wr_x_q;
  logic [w_y-1:0]      wr_y_q;
  logic [DX_WIDTH-1:0] wr_dx_q;
  logic [DY_WIDTH-1:0] wr_dy_q;

  logic                spawn_d;
  logic [2:0]          speed;
  logic [DX_WIDTH-1:0] spd_dx, dx_spawn;
  logic [DY_WIDTH-1:0] dy_spawn;
  logic [w_x:0]        r_ext;
  logic [w_x-1:0]      x_spawn;

  // Galois LFSR step, taps 0xB400
  assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

  // Spawn speed follows the score the sprite is spawned with (score_d)
`ifdef GAME_SEQ_SPEEDUP_EN
  logic [1:0] spd_sel;
  assign spd_sel = (score_d[3:2] > 2'd2) ? 2'd2 : score_d[3:2];
  assign speed   = 3'd1 + {1'b0, spd_sel};
`else
  assign speed = 3'd1;
`endif

  assign spd_dx   = DX_WIDTH'(speed);
  assign dx_spawn = lfsr_q[15] ? (DX_WIDTH'(0) - spd_dx) : spd_dx;
  assign dy_spawn = DY_WIDTH'(speed);

  // Fold the random value into 0..X_MAX; one subtraction suffices for legal sets
  assign r_ext   = {1'b0, lfsr_q[w_x-1:0]};
  assign x_spawn = (r_ext <= X_MAX_L) ? lfsr_q[w_x-1:0] : w_x'(r_ext - X_MAX_L);

  // Next-state and counter logic
  always_comb begin
    state_d  = state_q;
    lives_d  = lives_q;
    score_d  = score_q;
    bounce_d = bounce_q;
    pause_d  = pause_q;
    case (state_q)
      S_IDLE, S_GAME_OVER: begin
        if (launch) begin
          state_d = S_SPAWN;
          lives_d = 3'(LIVES_INIT);
          score_d = 8'd0;
        end
      end
      S_SPAWN: begin
        bounce_d = '0;
        state_d  = S_PLAY;
      end
      S_PLAY: begin
        // A catch wins over a same-cycle bounce
        if (collision) begin
          if (score_q != 8'hFF) score_d = score_q + 8'd1;
          state_d = S_SPAWN;
        end else if (tick && hit_wall) begin
          bounce_d = bounce_q + BW'(1);
          if (bounce_d == BW'(MAX_BOUNCES)) begin
            lives_d = lives_q - 3'd1;
            pause_d = '0;
            state_d = S_PAUSE;
          end
        end
      end
      S_PAUSE: begin
        if (tick) begin
          pause_d = pause_q + PW'(1);
          if (pause_q == PW'(PAUSE_TICKS - 1))
            state_d = (lives_q == 3'd0) ? S_GAME_OVER : S_SPAWN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign spawn_d = (state_d == S_SPAWN);

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lives_q     <= 3'd0;
      score_q     <= 8'd0;
      bounce_q    <= '0;
      pause_q     <= '0;
      lfsr_q      <= LFSR_SEED;
      enable_q    <= 1'b0;
      upd_q       <= 1'b0;
      game_over_q <= 1'b0;
      wr_xy_q     <= 1'b0;
      wr_dxy_q    <= 1'b0;
      wr_x_q      <= '0;
      wr_y_q      <= '0;
      wr_dx_q     <= '0;
      wr_dy_q     <= '0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      bounce_q    <= bounce_d;
      pause_q     <= pause_d;
      lfsr_q      <= lfsr_d;
      enable_q    <= (state_d == S_SPAWN) || (state_d == S_PLAY) || (state_d == S_PAUSE);
      upd_q       <= (state_d == S_PLAY);
      game_over_q <= (state_d == S_GAME_OVER);
      wr_xy_q     <= spawn_d;
      wr_dxy_q    <= spawn_d;
      if (spawn_d) begin
        wr_x_q  <= x_spawn;
        wr_y_q  <= w_y'(SPAWN_Y);
        wr_dx_q <= dx_spawn;
        wr_dy_q <= dy_spawn;
      end
    end
  end

  assign enable               = enable_q;
  assign sprite_enable_update = upd_q;
  assign sprite_write_xy      = wr_xy_q;
  assign sprite_write_x       = wr_x_q;
  assign sprite_write_y       = wr_y_q;
  assign sprite_write_dxy     = wr_dxy_q;
  assign sprite_write_dx      = wr_dx_q;
  assign sprite_write_dy      = wr_dy_q;
  assign lives                = lives_q;
  assign score                = score_q;
  assign game_over            = game_over_q;
  assign state                = state_q;

endmodule

// File: tb/tb_game_round_sequencer.sv
// Directed self-checking bench for game_round_sequencer (default parameters).
module tb_game_round_sequencer;

  logic       clk = 1'b0;
  logic       rst, tick, launch, collision, hit_wall;
  logic       enable, upd, wr_xy, wr_dxy, game_over;
  logic [9:0] wr_x;
  logic [8:0] wr_y;
  logic [2:0] wr_dx, wr_dy, lives, state;
  logic [7:0] score;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_score;

  // Reference LFSR; m_prev is the value the DUT saw on the last edge
  logic [15:0] m, m_prev;

  game_round_sequencer dut (
    .clk(clk), .rst(rst), .tick(tick), .launch(launch), .collision(collision),
    .hit_wall(hit_wall), .enable(enable), .sprite_enable_update(upd),
    .sprite_write_xy(wr_xy), .sprite_write_x(wr_x), .sprite_write_y(wr_y),
    .sprite_write_dxy(wr_dxy), .sprite_write_dx(wr_dx), .sprite_write_dy(wr_dy),
    .lives(lives), .score(score), .game_over(game_over), .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    m_prev <= m;
    if (rst) m <= 16'hACE1;
    else     m <= m[0] ? ((m >> 1) ^ 16'hB400) : (m >> 1);
  end

  function automatic logic [9:0] f_x(input logic [15:0] l);
    logic [9:0] r;
    r = l[9:0];
    return (r <= 10'd632) ? r : (r - 10'd632);
  endfunction

  function automatic logic [2:0] f_speed(input logic [7:0] s);
`ifdef GAME_SEQ_SPEEDUP_EN
    if (s[3:2] == 2'd0) return 3'd1;
    if (s[3:2] == 2'd1) return 3'd2;
    return 3'd3;
`else
    if (s == 8'hEE) return 3'd1;  // speed never depends on score here
    return 3'd1;
`endif
  endfunction

  function automatic logic [2:0] f_dx(input logic [15:0] l, input logic [2:0] spd);
    return l[15] ? (3'd0 - spd) : spd;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; cyc();
      tick = 1'b0; cyc();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 0; launch = 0; collision = 0; hit_wall = 0;
    cyc(); cyc();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (lives !== 3'd0 || score !== 8'd0) begin failures++; $display("FAIL reset_lives_score got=%0d/%0d exp=0/0", lives, score); end
    checks++; if ({enable, upd, wr_xy, wr_dxy, game_over} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {enable, upd, wr_xy, wr_dxy, game_over}); end
    checks++; if ({wr_x, wr_y, wr_dx, wr_dy} !== '0) begin failures++; $display("FAIL reset_write_vals got=%0d,%0d,%0d,%0d exp=0", wr_x, wr_y, wr_dx, wr_dy); end
    rst = 1'b0;
    cyc();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL idle_hold got=%0d exp=0", state); end
  endtask

  task automatic test_launch();
    logic [2:0] spd;
    launch = 1'b1; cyc(); launch = 1'b0;
    exp_score = 8'd0;
    spd = f_speed(exp_score);
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL launch_state got=%0d exp=1", state); end
    checks++; if (wr_xy !== 1'b1 || wr_dxy !== 1'b1) begin failures++; $display("FAIL launch_strobes got=%b%b exp=11", wr_xy, wr_dxy); end
    checks++; if (wr_x !== f_x(m_prev)) begin failures++; $display("FAIL launch_x got=%0d exp=%0d", wr_x, f_x(m_prev)); end
    checks++; if (wr_y !== 9'd0 || wr_dy !== spd) begin failures++; $display("FAIL launch_y_dy got=%0d/%0d exp=0/%0d", wr_y, wr_dy, spd); end
    checks++; if (wr_dx !== f_dx(m_prev, spd)) begin failures++; $display("FAIL launch_dx got=%0d exp=%0d", wr_dx, f_dx(m_prev, spd)); end
    checks++; if (lives !== 3'd3 || score !== 8'd0 || enable !== 1'b1 || upd !== 1'b0) begin failures++; $display("FAIL launch_status got=%0d/%0d/%b%b exp=3/0/10", lives, score, enable, upd); end
    cyc();
    checks++; if (state !== 3'd2 || upd !== 1'b1 || wr_xy !== 1'b0 || wr_dxy !== 1'b0) begin failures++; $display("FAIL play_entry got=%0d/%b%b%b exp=2/100", state, upd, wr_xy, wr_dxy); end
    // launch in PLAY is ignored
    launch = 1'b1; cyc(); launch = 1'b0;
    checks++; if (state !== 3'd2 || wr_xy !== 1'b0) begin failures++; $display("FAIL play_launch_ignored got=%0d/%b exp=2/0", state, wr_xy); end
  endtask

  task automatic test_collision();
    collision = 1'b1; cyc(); collision = 1'b0;
    exp_score = exp_score + 8'd1;
    checks++; if (state !== 3'd1 || score !== exp_score || wr_xy !== 1'b1) begin failures++; $display("FAIL collision_spawn got=%0d/%0d/%b exp=1/%0d/1", state, score, wr_xy, exp_score); end
    cyc();
    checks++; if (state !== 3'd2 || wr_xy !== 1'b0) begin failures++; $display("FAIL collision_one_spawn got=%0d/%b exp=2/0", state, wr_xy); end
  endtask

  task automatic test_life_loss();
    hit_wall = 1'b1;
    tick_n(7);
    checks++; if (state !== 3'd2 || lives !== 3'd3) begin failures++; $display("FAIL bounce7 got=%0d/%0d exp=2/3", state, lives); end
    tick_n(1);
    checks++; if (state !== 3'd3 || lives !== 3'd2 || enable !== 1'b1 || upd !== 1'b0) begin failures++; $display("FAIL bounce8_pause got=%0d/%0d/%b%b exp=3/2/10", state, lives, enable, upd); end
    collision = 1'b1; launch = 1'b1; cyc(); collision = 1'b0; launch = 1'b0;
    checks++; if (state !== 3'd3 || score !== exp_score || lives !== 3'd2) begin failures++; $display("FAIL pause_ignore got=%0d/%0d/%0d exp=3/%0d/2", state, score, lives, exp_score); end
    tick_n(15);
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL pause15 got=%0d exp=3", state); end
    tick = 1'b1; cyc(); tick = 1'b0;
    checks++; if (state !== 3'd1 || wr_xy !== 1'b1) begin failures++; $display("FAIL pause16_spawn got=%0d/%b exp=1/1", state, wr_xy); end
    cyc();
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL pause_to_play got=%0d exp=2", state); end
  endtask

  task automatic test_game_over();
    tick_n(8); tick_n(16);
    checks++; if (state !== 3'd2 || lives !== 3'd1) begin failures++; $display("FAIL second_loss got=%0d/%0d exp=2/1", state, lives); end
    tick_n(8);
    checks++; if (state !== 3'd3 || lives !== 3'd0) begin failures++; $display("FAIL third_loss got=%0d/%0d exp=3/0", state, lives); end
    tick_n(16);
    checks++; if (state !== 3'd4 || game_over !== 1'b1 || enable !== 1'b0 || upd !== 1'b0) begin failures++; $display("FAIL game_over got=%0d/%b%b%b exp=4/100", state, game_over, enable, upd); end
    checks++; if (lives !== 3'd0 || score !== exp_score) begin failures++; $display("FAIL game_over_hold got=%0d/%0d exp=0/%0d", lives, score, exp_score); end
    launch = 1'b1; cyc(); launch = 1'b0;
    exp_score = 8'd0;
    checks++; if (state !== 3'd1 || lives !== 3'd3 || score !== 8'd0 || game_over !== 1'b0) begin failures++; $display("FAIL relaunch got=%0d/%0d/%0d/%b exp=1/3/0/0", state, lives, score, game_over); end
    checks++; if (wr_x !== f_x(m_prev) || wr_dx !== f_dx(m_prev, f_speed(exp_score))) begin failures++; $display("FAIL relaunch_xdx got=%0d/%0d exp=%0d/%0d", wr_x, wr_dx, f_x(m_prev), f_dx(m_prev, f_speed(exp_score))); end
    cyc();
  endtask

  task automatic test_collision_priority();
    tick_n(7);
    collision = 1'b1; tick = 1'b1; cyc(); collision = 1'b0; tick = 1'b0;
    exp_score = exp_score + 8'd1;
    checks++; if (state !== 3'd1 || score !== exp_score || lives !== 3'd3) begin failures++; $display("FAIL priority got=%0d/%0d/%0d exp=1/%0d/3", state, score, lives, exp_score); end
    cyc();
    tick_n(7);
    checks++; if (state !== 3'd2 || lives !== 3'd3) begin failures++; $display("FAIL bounce_cleared got=%0d/%0d exp=2/3", state, lives); end
    tick_n(1);
    checks++; if (state !== 3'd3 || lives !== 3'd2) begin failures++; $display("FAIL bounce_recount got=%0d/%0d exp=3/2", state, lives); end
  endtask

  task automatic test_reset_mid();
    tick_n(3);
    rst = 1'b1; cyc();
    checks++; if (state !== 3'd0 || lives !== 3'd0 || score !== 8'd0) begin failures++; $display("FAIL midreset_state got=%0d/%0d/%0d exp=0/0/0", state, lives, score); end
    checks++; if ({enable, upd, wr_xy, wr_dxy, game_over} !== 5'b0 || {wr_x, wr_y, wr_dx, wr_dy} !== '0) begin failures++; $display("FAIL midreset_outputs got=%b/%0d exp=00000/0", {enable, upd, wr_xy, wr_dxy, game_over}, wr_x); end
    rst = 1'b0; hit_wall = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [2:0] spd;
    launch = 1'b1; cyc(); launch = 1'b0; cyc();
    exp_score = 8'd0;
    for (int i = 0; i < 260; i++) begin
      collision = 1'b1; cyc(); collision = 1'b0;
      if (exp_score != 8'hFF) exp_score = exp_score + 8'd1;
      spd = f_speed(exp_score);
      if (i < 6 || i == 259) begin
        checks++; if (score !== exp_score) begin failures++; $display("FAIL b2b_score[%0d] got=%0d exp=%0d", i, score, exp_score); end
        checks++; if (wr_dy !== spd || wr_dx !== f_dx(m_prev, spd)) begin failures++; $display("FAIL b2b_speed[%0d] got=%0d/%0d exp=%0d/%0d", i, wr_dx, wr_dy, f_dx(m_prev, spd), spd); end
      end
      cyc();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_launch();
    test_collision();
    test_life_loss();
    test_game_over();
    test_collision_priority();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_round_sequencer.md
Name: game_round_sequencer

Overview:
Round-level controller for one bouncing sprite driven by game_sprite_control. It spawns the sprite and loads its position and velocity through the write ports, then gates movement updates. It counts wall bounces from hit_wall and scores catches from an external collision input. It tracks lives and sequences the IDLE → SPAWN → PLAY → PAUSE → GAME_OVER flow.

Parameters:
screen_width, 640, screen width in pixels
screen_height, 480, screen height in pixels
SPRITE_WIDTH, 8, sprite width in pixels
w_x, $clog2(screen_width), x coordinate width
w_y, $clog2(screen_height), y coordinate width
DX_WIDTH, 3, signed dx width
DY_WIDTH, 3, signed dy width
SPAWN_Y, 0, y loaded at spawn
LIVES_INIT, 3, lives loaded on launch (1..7)
MAX_BOUNCES, 8, wall bounces per life before the life is lost
PAUSE_TICKS, 16, ticks spent in PAUSE
LFSR_SEED, 16'hACE1, nonzero LFSR reset value

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
tick  in  1  slow movement strobe; same strobe as used by the sprite block
launch  in  1  start/restart pulse
collision  in  1  player caught sprite, level-sampled
hit_wall  in  1  from sprite block, combinational
enable  out  1  sprite block enable
sprite_enable_update  out  1  allow motion updates
sprite_write_xy  out  1  load-position strobe
sprite_write_x  out  w_x  spawn x
sprite_write_y  out  w_y  spawn y
sprite_write_dxy  out  1  load-velocity strobe
sprite_write_dx  out  DX_WIDTH  signed spawn dx
sprite_write_dy  out  DY_WIDTH  signed spawn dy
lives  out  3  remaining lives
score  out  8  catches, saturating
game_over  out  1  high in GAME_OVER state
state  out  3  encoded FSM state for debug

Behaviour:
- All registers are reset by rst on the clk edge. State=IDLE, lives=0, score=0, bounce_cnt=0, pause_cnt=0, LFSR=LFSR_SEED. All strobes are 0; write_x/y/dx/dy=0; game_over=0.
- Reset mid-round aborts to IDLE the next cycle. No write strobes are emitted in that cycle.
- LFSR: 16-bit Galois, taps 0xB400, advances every cycle while not in reset.
- Outputs per state:
  - enable=1 in SPAWN, PLAY and PAUSE; 0 in IDLE and GAME_OVER.
  - sprite_enable_update=1 only in PLAY.
- IDLE: launch → SPAWN; lives←LIVES_INIT, score←0.
- SPAWN (exactly 1 cycle):
  - sprite_write_xy=1 and sprite_write_dxy=1, both registered with the state entry.
  - x = r if r ≤ X_MAX else r−X_MAX, where r = lfsr[w_x-1:0] and X_MAX = screen_width−SPRITE_WIDTH. Legal parameter sets satisfy 2·X_MAX ≥ 2^w_x.
  - y=SPAWN_Y. dx = lfsr[15] ? −speed : +speed. dy=+speed.
  - bounce_cnt←0. Next state PLAY.
- PLAY:
  - collision=1 → score+1, saturating at 255; → SPAWN.
  - Otherwise, if tick && hit_wall → bounce_cnt+1. If this bounce reaches MAX_BOUNCES: lives−1, pause_cnt←0, → PAUSE.
  - collision has priority over a same-cycle bounce; the bounce is not counted.
  - launch is ignored.
- PAUSE: pause_cnt+1 per tick. When pause_cnt=PAUSE_TICKS−1 and tick → GAME_OVER if lives=0, else SPAWN. launch and collision are ignored.
- GAME_OVER: game_over=1; lives and score held. launch → SPAWN with lives←LIVES_INIT, score←0.
- Write-port values hold their last value outside SPAWN.
- Base speed is 1.
- State encoding: IDLE=0, SPAWN=1, PLAY=2, PAUSE=3, GAME_OVER=4.

Optional Feature:
GAME_SEQ_SPEEDUP_EN:
- Defined: speed = 1 + min(score[3:2], 2), giving a magnitude range of 1..3. Requires DX_WIDTH and DY_WIDTH ≥ 3.
- Undefined: speed is always 1 and no speed logic exists.

Test Plan:
- Reset then launch pulse → SPAWN for 1 cycle with write_xy=write_dxy=1. From seed 0xACE1: x=r or r−632, y=0, dy=+1. Then PLAY, lives=3, score=0.
- In PLAY, assert collision for 1 cycle → score=1, exactly one SPAWN cycle, then PLAY with bounce_cnt=0.
- Hold hit_wall=1 and pulse tick 8 times → lives 3→2, PAUSE entered; after 16 ticks → SPAWN.
- Repeat the life loss 3 times → GAME_OVER, game_over=1, enable=0. launch → lives=3, score=0, SPAWN.
- collision=1 and tick&&hit_wall in the same cycle at bounce_cnt=7 → score+1, lives unchanged, SPAWN.
- Assert rst during PAUSE → IDLE next cycle, all outputs at reset values. With GAME_SEQ_SPEEDUP_EN defined, score=4 → next spawn |dx|=|dy|=2.
